// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-80 encryptor.
// Provides datapath widths, the default round count, the control FSM state
// type, and the S-box, permutation-layer and key-schedule helpers.
package present_pkg;

  localparam int unsigned DATA_W      = 64;
  localparam int unsigned KEY_W       = 80;
  localparam int unsigned NROUNDS_DEF = 31;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  // PRESENT 4-bit S-box
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Bit i moves to (16*i) mod 63; bit 63 stays in place.
  function automatic logic [DATA_W-1:0] p_layer(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < 63; i++)
      p[6'((16 * i) % 63)] = d[6'(i)];
    p[63] = d[63];
    return p;
  endfunction

  // Rotate left 61, S-box the top nibble, fold the round counter into [19:15].
  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                  input logic [4:0]       r);
    logic [KEY_W-1:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ r;
    return t;
  endfunction

endpackage

// File: rtl/present_if.sv
// Register-bank side bus of the PRESENT encryptor.
//   chip_enable, load, idat, key : driven by the bank (master)
//   odat, done, busy             : driven by the encryptor (slave)
interface present_if;
  import present_pkg::*;

  logic              chip_enable;
  logic              load;
  logic [DATA_W-1:0] idat;
  logic [KEY_W-1:0]  key;
  logic [DATA_W-1:0] odat;
  logic              done;
  logic              busy;

  modport master (output chip_enable, load, idat, key,
                  input  odat, done, busy);
  modport slave  (input  chip_enable, load, idat, key,
                  output odat, done, busy);
endinterface

// File: rtl/present_encrypt_round.sv
// One PRESENT round, purely combinational.
//   dreg/kreg : current state and key register
//   round     : 5-bit round counter fed to the key schedule
//   d_nxt     : pLayer(sLayer(dreg ^ kreg[79:16]))
//   k_nxt     : key register after the schedule update
module present_round
  import present_pkg::*;
(
  input  logic [DATA_W-1:0] dreg,
  input  logic [KEY_W-1:0]  kreg,
  input  logic [4:0]        round,
  output logic [DATA_W-1:0] d_nxt,
  output logic [KEY_W-1:0]  k_nxt
);

  logic [DATA_W-1:0] s_in;
  logic [DATA_W-1:0] s_out;

  assign s_in = dreg ^ kreg[79:16];

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    assign s_out[4*g +: 4] = sbox(s_in[4*g +: 4]);
  end

  assign d_nxt = p_layer(s_out);
  assign k_nxt = key_update(kreg, round);

endmodule

// File: rtl/present_encrypt.sv
// Iterative PRESENT-80 encryptor, one round per enabled clock.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of present_if (chip_enable/load/idat/key in,
//                odat/done/busy out)
// load samples idat/key and (re)starts; 31 rounds follow, then a final key
// addition writes odat and pulses done.
module present_encrypt
  import present_pkg::*;
#(
  parameter int unsigned NROUNDS = NROUNDS_DEF
)(
  input  logic clk,
  input  logic rst_n,
  present_if.slave bus
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] dreg, d_nxt, odat_r;
  logic [KEY_W-1:0]  kreg, k_nxt;
  logic [4:0]        round;
  logic              done_r, busy_r;
  logic              last_round;

  assign last_round = (round == 5'(NROUNDS));

  present_round u_round (
    .dreg  (dreg),
    .kreg  (kreg),
    .round (round),
    .d_nxt (d_nxt),
    .k_nxt (k_nxt)
  );

  always_comb begin
    state_nxt = state;
    if (bus.load) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        RUN:     if (last_round) state_nxt = FINISH;
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (bus.chip_enable) state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dreg   <= '0;
      kreg   <= '0;
      odat_r <= '0;
      round  <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else if (bus.chip_enable) begin
      if (bus.load) begin
        dreg   <= bus.idat;
        kreg   <= bus.key;
        round  <= 5'd1;
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end else begin
        unique case (state)
          RUN: begin
            dreg   <= d_nxt;
            kreg   <= k_nxt;
            done_r <= 1'b0;
            // Terminal count is tested before increment so round never wraps.
            if (!last_round) round <= round + 5'd1;
          end
          FINISH: begin
            odat_r <= dreg ^ kreg[79:16];
            done_r <= 1'b1;
            busy_r <= 1'b0;
            round  <= '0;
          end
          default: done_r <= 1'b0;
        endcase
      end
    end
  end

  assign bus.odat = odat_r;
  assign bus.done = done_r & bus.chip_enable;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_present_encrypt.sv
// Directed bench for present_encrypt: known-answer vectors, latency, abort,
// chip_enable stall, mid-run reset, held load, and a round trip through a
// decryption model.
module tb_present_encrypt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  present_if bus ();

  present_encrypt #(.NROUNDS(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [79:0] k, input logic [63:0] d);
    bus.key  = k;
    bus.idat = d;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  // Cycles after the load edge until done is seen; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (bus.done) nd++;
    end
  endtask

  // Independent PRESENT-80 decryption used for the round-trip test.
  function automatic logic [63:0] decrypt(input logic [63:0] c, input logic [79:0] k);
    logic [63:0] tbl;
    logic [3:0]  sb [16];
    logic [3:0]  isb [16];
    logic [63:0] rk [33];
    logic [79:0] kk;
    logic [63:0] s, q;
    logic [4:0]  rc;
    tbl = 64'hC56B90AD3EF84712;
    for (int i = 0; i < 16; i++) sb[i] = 4'(tbl >> (60 - 4 * i));
    for (int i = 0; i < 16; i++) isb[sb[i]] = 4'(i);
    kk = k;
    for (int r = 1; r <= 32; r++) begin
      rk[r] = kk[79:16];
      rc = 5'(r);
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = sb[kk[79:76]];
      kk[19:15] = kk[19:15] ^ rc;
    end
    s = c ^ rk[32];
    for (int r = 31; r >= 1; r--) begin
      q = '0;
      for (int i = 0; i < 63; i++) q[i] = s[(16 * i) % 63];
      q[63] = s[63];
      for (int n = 0; n < 16; n++) q[4*n +: 4] = isb[q[4*n +: 4]];
      s = q ^ rk[r];
    end
    return s;
  endfunction

  localparam logic [79:0] K0 = '0;
  localparam logic [79:0] K1 = '1;
  localparam logic [63:0] D0 = '0;
  localparam logic [63:0] D1 = '1;

  initial begin
    int lat, nd;
    logic [79:0] rk;
    logic [63:0] rd;

    bus.chip_enable = 1'b1;
    bus.load = 1'b0;
    bus.idat = '0;
    bus.key  = '0;
    #2;
    check_eq("reset_odat", bus.odat, 64'h0);
    check_eq("reset_done", 64'(bus.done), 64'h0);
    check_eq("reset_busy", 64'(bus.busy), 64'h0);
    #20 rst_n = 1'b1;
    tick();

    // Vector 1 with latency, busy and single-pulse checks
    start(K0, D0);
    check_eq("v1_busy", 64'(bus.busy), 64'h1);
    wait_done(lat);
    check_eq("v1_lat", 64'(lat), 64'd32);
    check_eq("v1_odat", bus.odat, 64'h5579C1387B228445);
    check_eq("v1_busy_end", 64'(bus.busy), 64'h0);
    tick();
    check_eq("v1_done_pulse", 64'(bus.done), 64'h0);

    // Vector 2; odat must survive the new load
    start(K1, D0);
    check_eq("v2_odat_kept", bus.odat, 64'h5579C1387B228445);
    wait_done(lat);
    check_eq("v2_lat", 64'(lat), 64'd32);
    check_eq("v2_odat", bus.odat, 64'hE72C46C0F5945049);

    // Vector 3
    start(K0, D1);
    wait_done(lat);
    check_eq("v3_odat", bus.odat, 64'hA112FFC72F68417B);

    // Abort vector 3 with vector 4 after 10 cycles
    start(K0, D1);
    repeat (9) tick();
    start(K1, D1);
    wait_done(lat);
    check_eq("abort_lat", 64'(lat), 64'd32);
    check_eq("abort_odat", bus.odat, 64'h3333DCD3213210D2);
    count_done(40, nd);
    check_eq("abort_extra_done", 64'(nd), 64'd0);

    // chip_enable low for 5 cycles mid-run
    start(K0, D0);
    repeat (4) tick();
    bus.chip_enable = 1'b0;
    repeat (5) tick();
    bus.chip_enable = 1'b1;
    wait_done(lat);
    check_eq("ce_lat", 64'(lat + 9), 64'd37);
    check_eq("ce_odat", bus.odat, 64'h5579C1387B228445);

    // Reset mid-run
    start(K1, D0);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_odat", bus.odat, 64'h0);
    check_eq("rst_busy", 64'(bus.busy), 64'h0);
    #3 rst_n = 1'b1;
    count_done(40, nd);
    check_eq("rst_no_done", 64'(nd), 64'd0);

    // load held high restarts every cycle and never completes
    bus.key  = K1;
    bus.idat = D1;
    bus.load = 1'b1;
    count_done(40, nd);
    check_eq("hold_no_done", 64'(nd), 64'd0);
    check_eq("hold_busy", 64'(bus.busy), 64'h1);
    bus.load = 1'b0;
    wait_done(lat);
    check_eq("hold_release_lat", 64'(lat), 64'd32);
    check_eq("hold_release_odat", bus.odat, 64'h3333DCD3213210D2);

    // Round trip through the decryption model
    for (int t = 0; t < 20; t++) begin
      rk = {$urandom, $urandom, 16'($urandom)};
      rd = {$urandom, $urandom};
      start(rk, rd);
      wait_done(lat);
      check_eq($sformatf("roundtrip%0d", t), decrypt(bus.odat, rk), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
